// File: rtl/cb_filter_arb_pkg.sv
// Shared types and round-robin helpers for the counting bloom filter arbiter.
package cb_filter_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    CLEAR = 2'd1,
    ERROR = 2'd2
  } arb_state_e;

  // Pointer value following a grant to index ptr among n requesters.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

  // Index reached by stepping off places from base, wrapping at n.
  function automatic int unsigned rr_wrap(input int unsigned base, input int unsigned off,
                                          input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/cb_filter_arb_rr.sv
// Round-robin arbiter with valid/ready handshake and data mux.
// The pointer names the requester with highest priority; it moves past the winner.
module cb_rr_arb
  import cb_filter_arb_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned DataWidth = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           en_i,
  input  logic [N-1:0]                   valid_i,
  input  logic [N-1:0][DataWidth-1:0]    data_i,
  output logic [N-1:0]                   ready_o,
  output logic                           valid_o,
  output logic [DataWidth-1:0]           data_o
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] cand;
  logic [PtrW-1:0] grant_idx;
  logic            found;

  // Search for the first valid requester at or after the pointer, wrapping.
  always_comb begin
    found     = 1'b0;
    grant_idx = ptr_q;
    cand      = ptr_q;
    for (int unsigned i = 0; i < N; i++) begin
      cand = PtrW'(rr_wrap(32'(ptr_q), i, N));
      if (!found && valid_i[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Drive the one-hot grant and the forwarded data (zero when idle).
  always_comb begin
    ready_o = '0;
    data_o  = '0;
    valid_o = en_i & found;
    if (valid_o) begin
      ready_o[grant_idx] = 1'b1;
      data_o             = data_i[grant_idx];
    end
  end

  // Advance the priority pointer past the requester that was just served.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (valid_o) begin
      ptr_q <= PtrW'(rr_next(32'(grant_idx), N));
    end
  end

endmodule

// File: rtl/cb_filter_arb.sv
// Front end of a shared counting bloom filter: arbitrates insert and remove
// requesters, sequences clears, blocks inserts when full and latches errors.
module cb_filter_arb
  import cb_filter_arb_pkg::*;
#(
  parameter int unsigned NumIncr       = 4,
  parameter int unsigned NumDecr       = 4,
  parameter int unsigned InpWidth      = 32,
  parameter int unsigned HashWidth     = 4,
  parameter int unsigned StallCntWidth = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumIncr-1:0]                incr_valid_i,
  input  logic [NumIncr-1:0][InpWidth-1:0]  incr_data_i,
  output logic [NumIncr-1:0]                incr_ready_o,
  input  logic [NumDecr-1:0]                decr_valid_i,
  input  logic [NumDecr-1:0][InpWidth-1:0]  decr_data_i,
  output logic [NumDecr-1:0]                decr_ready_o,
  input  logic                              clear_req_i,
  output logic                              clear_ack_o,
  output logic                              filter_incr_valid_o,
  output logic [InpWidth-1:0]               filter_incr_data_o,
  output logic                              filter_decr_valid_o,
  output logic [InpWidth-1:0]               filter_decr_data_o,
  output logic                              filter_clear_o,
  input  logic [HashWidth-1:0]              filter_usage_i,
  input  logic                              filter_full_i,
  input  logic                              filter_error_i,
  output logic                              err_o,
  output logic [StallCntWidth-1:0]          incr_stall_cnt_o
);

  arb_state_e               state_q;
  logic                     clear_q;
  logic                     err_q;
  logic [StallCntWidth-1:0] stall_q;
  logic                     incr_block;
  logic                     grant_en;
  logic                     incr_en;

  // Inserts stop once the filter reports full or its usage counter is pinned.
  assign incr_block = filter_full_i | (filter_usage_i == {HashWidth{1'b1}});
  // A pending clear request pre-empts grants so the clear sees a quiet filter.
  assign grant_en   = (state_q == RUN) & ~clear_req_i;
  assign incr_en    = grant_en & ~incr_block;

  cb_rr_arb #(
    .N         (NumIncr),
    .DataWidth (InpWidth)
  ) u_incr_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (incr_en),
    .valid_i (incr_valid_i),
    .data_i  (incr_data_i),
    .ready_o (incr_ready_o),
    .valid_o (filter_incr_valid_o),
    .data_o  (filter_incr_data_o)
  );

  cb_rr_arb #(
    .N         (NumDecr),
    .DataWidth (InpWidth)
  ) u_decr_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (grant_en),
    .valid_i (decr_valid_i),
    .data_i  (decr_data_i),
    .ready_o (decr_ready_o),
    .valid_o (filter_decr_valid_o),
    .data_o  (filter_decr_data_o)
  );

  // Control FSM: one-cycle clear pulse, sticky error cleared by the clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RUN;
      clear_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (clear_req_i) begin
            state_q <= CLEAR;
            clear_q <= 1'b1;
          end else if (filter_error_i) begin
            state_q <= ERROR;
            err_q   <= 1'b1;
          end
        end
        CLEAR: begin
          state_q <= RUN;
          err_q   <= 1'b0;
        end
        ERROR: begin
          if (clear_req_i) begin
            state_q <= CLEAR;
            clear_q <= 1'b1;
          end
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  // Saturating count of cycles in which an insert was pending but blocked.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (state_q == CLEAR) begin
      stall_q <= '0;
    end else if (grant_en && incr_block && (|incr_valid_i) && (stall_q != '1)) begin
      stall_q <= stall_q + StallCntWidth'(1);
    end
  end

  assign filter_clear_o   = clear_q;
  assign clear_ack_o      = clear_q;
  assign err_o            = err_q;
  assign incr_stall_cnt_o = stall_q;

endmodule

// File: tb/tb_cb_filter_arb.sv
// Self-checking bench for cb_filter_arb: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the arbiter.
module tb_cb_filter_arb;

  localparam int NI = 4;
  localparam int ND = 4;
  localparam int IW = 32;
  localparam int HW = 4;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_ni;
  logic [NI-1:0]           incr_valid;
  logic [NI-1:0][IW-1:0]   incr_data;
  logic [NI-1:0]           incr_ready;
  logic [ND-1:0]           decr_valid;
  logic [ND-1:0][IW-1:0]   decr_data;
  logic [ND-1:0]           decr_ready;
  logic                    clear_req;
  logic                    clear_ack;
  logic                    f_incr_valid;
  logic [IW-1:0]           f_incr_data;
  logic                    f_decr_valid;
  logic [IW-1:0]           f_decr_data;
  logic                    f_clear;
  logic [HW-1:0]           f_usage;
  logic                    f_full;
  logic                    f_error;
  logic                    err;
  logic [SW-1:0]           stall_cnt;

  cb_filter_arb #(
    .NumIncr       (NI),
    .NumDecr       (ND),
    .InpWidth      (IW),
    .HashWidth     (HW),
    .StallCntWidth (SW)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .incr_valid_i        (incr_valid),
    .incr_data_i         (incr_data),
    .incr_ready_o        (incr_ready),
    .decr_valid_i        (decr_valid),
    .decr_data_i         (decr_data),
    .decr_ready_o        (decr_ready),
    .clear_req_i         (clear_req),
    .clear_ack_o         (clear_ack),
    .filter_incr_valid_o (f_incr_valid),
    .filter_incr_data_o  (f_incr_data),
    .filter_decr_valid_o (f_decr_valid),
    .filter_decr_data_o  (f_decr_data),
    .filter_clear_o      (f_clear),
    .filter_usage_i      (f_usage),
    .filter_full_i       (f_full),
    .filter_error_i      (f_error),
    .err_o               (err),
    .incr_stall_cnt_o    (stall_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_in_clear;   // this cycle is the clear cycle
  bit m_in_error;   // halted after a filter error
  bit m_err;        // value err_o should show
  int m_iptr;
  int m_dptr;
  int m_stall;
  int gi;
  int gd;
  bit m_blk;

  function automatic int pick(input logic [3:0] v, input int ptr, input int n);
    for (int o = 0; o < n; o++) begin
      int k;
      k = (ptr + o) % n;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_clear = 0;
    m_in_error = 0;
    m_err      = 0;
    m_iptr     = 0;
    m_dptr     = 0;
    m_stall    = 0;
  endtask

  task automatic check_cycle();
    logic [NI-1:0] e_ir;
    logic [ND-1:0] e_dr;
    logic [IW-1:0] e_id;
    logic [IW-1:0] e_dd;
    bit run;
    run   = !m_in_clear && !m_in_error && !clear_req;
    m_blk = f_full || (f_usage == 4'd15);
    gi    = (run && !m_blk) ? pick(incr_valid, m_iptr, NI) : -1;
    gd    = run ? pick(decr_valid, m_dptr, ND) : -1;
    e_ir = '0; e_id = '0; e_dr = '0; e_dd = '0;
    if (gi >= 0) begin e_ir[gi] = 1'b1; e_id = incr_data[gi]; end
    if (gd >= 0) begin e_dr[gd] = 1'b1; e_dd = decr_data[gd]; end
    cmp("incr_ready", 32'(incr_ready), 32'(e_ir));
    cmp("decr_ready", 32'(decr_ready), 32'(e_dr));
    cmp("f_incr_valid", 32'(f_incr_valid), 32'(gi >= 0));
    cmp("f_incr_data", f_incr_data, e_id);
    cmp("f_decr_valid", 32'(f_decr_valid), 32'(gd >= 0));
    cmp("f_decr_data", f_decr_data, e_dd);
    cmp("filter_clear", 32'(f_clear), 32'(m_in_clear));
    cmp("clear_ack", 32'(clear_ack), 32'(m_in_clear));
    cmp("err", 32'(err), 32'(m_err));
    cmp("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  task automatic advance();
    if (!rst_ni) begin
      model_reset();
      return;
    end
    if (gi >= 0) m_iptr = (gi + 1) % NI;
    if (gd >= 0) m_dptr = (gd + 1) % ND;
    if (m_in_clear) begin
      m_in_clear = 0;
      m_in_error = 0;
      m_err      = 0;
      m_stall    = 0;
    end else if (m_in_error) begin
      if (clear_req) m_in_clear = 1;
    end else begin
      if (!clear_req && (|incr_valid) && m_blk && m_stall < 15) m_stall++;
      if (clear_req) m_in_clear = 1;
      else if (f_error) begin
        m_in_error = 1;
        m_err      = 1;
      end
    end
  endtask

  // One clock: settle, compare, take the edge, update the model.
  task automatic step();
    #2;
    if (rst_ni) check_cycle();
    @(posedge clk);
    #1;
    advance();
  endtask

  task automatic idle_inputs();
    incr_valid = '0;
    decr_valid = '0;
    clear_req  = 1'b0;
    f_usage    = '0;
    f_full     = 1'b0;
    f_error    = 1'b0;
    for (int i = 0; i < NI; i++) incr_data[i] = 32'h1000_0000 + i;
    for (int i = 0; i < ND; i++) decr_data[i] = 32'h2000_0000 + i;
  endtask

  initial begin
    model_reset();
    gi = -1;
    gd = -1;
    idle_inputs();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;

    // Reset state with no requests
    step();

    // Fairness: all inserters requesting
    incr_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      cmp("fair_ptr", 32'(m_iptr), 32'(c % 4));
      step();
    end

    // Full block with a concurrent remove
    incr_valid = 4'b0001;
    decr_valid = 4'b0100;
    f_usage    = 4'd15;
    for (int c = 0; c < 5; c++) step();
    cmp("stall_after_block", 32'(stall_cnt), 32'd5);

    // Clear pulse with requests pending
    f_usage    = 4'd3;
    incr_valid = 4'b0110;
    clear_req  = 1'b1;
    step();
    clear_req  = 1'b0;
    step();
    step();
    step();
    cmp("stall_after_clear", 32'(stall_cnt), 32'd0);

    // Filter error: halt until cleared
    f_error = 1'b1;
    step();
    f_error = 1'b0;
    for (int c = 0; c < 4; c++) step();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    step();
    step();
    step();

    // Reset in the middle of a clear
    incr_valid = 4'b0000;
    decr_valid = 4'b0000;
    clear_req  = 1'b1;
    step();
    clear_req  = 1'b0;
    rst_ni     = 1'b0;
    step();
    rst_ni     = 1'b1;
    incr_valid = 4'b1010;
    decr_valid = 4'b1100;
    step();
    step();

    // Saturation of the stall counter
    f_full     = 1'b1;
    incr_valid = 4'b0100;
    for (int c = 0; c < 20; c++) step();
    cmp("stall_saturated", 32'(stall_cnt), 32'd15);
    f_full = 1'b0;

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      incr_valid = 4'($urandom);
      decr_valid = 4'($urandom);
      for (int i = 0; i < NI; i++) incr_data[i] = $urandom;
      for (int i = 0; i < ND; i++) decr_data[i] = $urandom;
      f_usage   = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      f_full    = ($urandom_range(0, 7) == 0);
      f_error   = ($urandom_range(0, 24) == 0);
      clear_req = ($urandom_range(0, 14) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
